// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: synchronises and deglitches the bus,
// deserialises 11-bit frames and strobes good bytes, errors and BAT codes.
module ps2_frame_receiver #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_LEN    = 4,
   parameter int unsigned FILTER_WIDTH  = 3,
   parameter int unsigned TIMEOUT_COUNT = 50000,
   parameter int unsigned TIMEOUT_WIDTH = 16,
   parameter logic [7:0]  BAT_CODE      = 8'hAA
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       inhibit,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_error,
   output logic       reset_required,
   output logic       busy
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t                   state;
   logic [SYNC_STAGES-1:0]   sync_clk;
   logic [SYNC_STAGES-1:0]   sync_data;
   logic [1:0]               sync_out;
   logic [1:0]               filt;          // [0] = clock line, [1] = data line
   logic [FILTER_WIDTH-1:0]  fcnt [2];
   logic                     clk_prev;
   logic                     fall_c;
   logic                     data_c;
   logic [CNT_W-1:0]         bit_cnt;
   logic [TIMEOUT_WIDTH-1:0] to_cnt;
   logic [7:0]               shift_reg;
   logic                     parity_bit;
   logic                     stop_bit;
   logic                     frame_ok_c;

   assign sync_out   = {sync_data[SYNC_STAGES-1], sync_clk[SYNC_STAGES-1]};
   assign fall_c     = clk_prev & ~filt[0];
   assign data_c     = filt[1];
   assign frame_ok_c = ((^shift_reg) ^ parity_bit) & stop_bit;

   // Metastability synchroniser on both raw lines; resets to idle-high bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_clk  <= '1;
         sync_data <= '1;
      end else begin
         sync_clk  <= {sync_clk[SYNC_STAGES-2:0], ps2_clk};
         sync_data <= {sync_data[SYNC_STAGES-2:0], ps2_data};
      end
   end

   // Glitch filter: a line only changes after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt     <= 2'b11;
         clk_prev <= 1'b1;
         for (int i = 0; i < 2; i++) fcnt[i] <= '0;
      end else begin
         clk_prev <= filt[0];
         for (int i = 0; i < 2; i++) begin
            if (sync_out[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FILTER_WIDTH'(FILTER_LEN - 1)) begin
               filt[i] <= sync_out[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + FILTER_WIDTH'(1);
            end
         end
      end
   end

   // Frame state machine with registered strobes; inhibit aborts silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         bit_cnt        <= '0;
         to_cnt         <= '0;
         shift_reg      <= '0;
         parity_bit     <= 1'b0;
         stop_bit       <= 1'b0;
         data_out       <= '0;
         data_valid     <= 1'b0;
         frame_error    <= 1'b0;
         reset_required <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_valid     <= 1'b0;
         frame_error    <= 1'b0;
         reset_required <= 1'b0;
         if (inhibit) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            to_cnt  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (fall_c && !data_c) begin
                     state   <= RECV;
                     busy    <= 1'b1;
                     bit_cnt <= '0;
                     to_cnt  <= '0;
                  end
               end
               RECV: begin
                  if (fall_c) begin
                     to_cnt  <= '0;
                     bit_cnt <= bit_cnt + CNT_W'(1);
                     if (bit_cnt < CNT_W'(8)) begin
                        shift_reg[bit_cnt[2:0]] <= data_c;
                     end else if (bit_cnt == CNT_W'(8)) begin
                        parity_bit <= data_c;
                     end else begin
                        stop_bit <= data_c;
                        state    <= CHECK;
                     end
                  end else if (to_cnt == TIMEOUT_WIDTH'(TIMEOUT_COUNT - 1)) begin
                     state       <= IDLE;
                     busy        <= 1'b0;
                     bit_cnt     <= '0;
                     to_cnt      <= '0;
                     frame_error <= 1'b1;
                  end else begin
                     to_cnt <= to_cnt + TIMEOUT_WIDTH'(1);
                  end
               end
               CHECK: begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  bit_cnt <= '0;
                  to_cnt  <= '0;
                  if (frame_ok_c) begin
                     data_out       <= shift_reg;
                     data_valid     <= 1'b1;
                     reset_required <= (shift_reg == BAT_CODE);
                  end else begin
                     frame_error <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: stimulus pushes expected strobes,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_ps2_frame_receiver;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       inhibit;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_error;
   logic       reset_required;
   logic       busy;

   typedef struct packed {
      logic       v;
      logic       err;
      logic       rr;
      logic [7:0] data;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   fall_cyc = 0;
   int   err_cyc = 0;
   logic err_seen = 1'b0;
   logic prev_strobe = 1'b0;
   logic busy_seen;
   logic [7:0] last_good = 8'h00;

   ps2_frame_receiver #(
      .SYNC_STAGES(2), .FILTER_LEN(4), .FILTER_WIDTH(3),
      .TIMEOUT_COUNT(200), .TIMEOUT_WIDTH(16), .BAT_CODE(8'hAA)
   ) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .inhibit(inhibit), .data_out(data_out), .data_valid(data_valid),
      .frame_error(frame_error), .reset_required(reset_required), .busy(busy)
   );

   always #5 clk = ~clk;

   // Free-running cycle count used for timeout latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the head of the expectation queue.
   always @(negedge clk) begin
      exp_t e;
      logic strobe;
      if (rst) begin
         prev_strobe = 1'b0;
      end else begin
         strobe = data_valid | frame_error | reset_required;
         if (strobe) begin
            chk("strobe_not_consecutive", 16'(prev_strobe), 16'(0));
            if (frame_error) begin
               err_seen = 1'b1;
               err_cyc  = cyc;
            end
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_strobe: got v=%0b err=%0b rr=%0b want none",
                        data_valid, frame_error, reset_required);
            end else begin
               e = q.pop_front();
               chk("data_valid", 16'(data_valid), 16'(e.v));
               chk("frame_error", 16'(frame_error), 16'(e.err));
               chk("reset_required", 16'(reset_required), 16'(e.rr));
               chk("data_out", 16'(data_out), 16'(e.data));
            end
         end
         prev_strobe = strobe;
      end
   end

   // Drive nbits of a frame LSB first; optional 2-cycle data glitch just before one fall.
   task automatic drive_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         if (i == glitch_bit) begin
            repeat (6) @(negedge clk);
            ps2_data = ~bits[i];
            repeat (2) @(negedge clk);
            ps2_data = bits[i];
            repeat (2) @(negedge clk);
         end else begin
            repeat (10) @(negedge clk);
         end
         ps2_clk  = 1'b0;
         fall_cyc = cyc;
         repeat (20) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (10) @(negedge clk);
      end
      ps2_data = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL %s: got %0d pending strobes want 0", name, q.size());
         q.delete();
      end
   endtask

   task automatic send_frame(input string name, input logic [7:0] b, input logic par,
                             input logic stop, input int glitch_bit);
      exp_t e;
      logic good;
      good   = ((^b) ^ par) & stop;
      e.v    = good;
      e.err  = ~good;
      e.rr   = good & (b == 8'hAA);
      e.data = good ? b : last_good;
      if (good) last_good = b;
      q.push_back(e);
      drive_bits({stop, par, b, 1'b0}, 11, glitch_bit);
      repeat (40) @(negedge clk);
      wait_drain(name);
      chk({name, "_busy_after"}, 16'(busy), 16'(0));
   endtask

   initial begin
      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      inhibit  = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_data_out", 16'(data_out), 16'(0));
      chk("reset_strobes", 16'({data_valid, frame_error, reset_required}), 16'(0));
      chk("reset_busy", 16'(busy), 16'(0));
      repeat (20) @(negedge clk);

      // Good frames: plain byte and BAT code.
      send_frame("f1c", 8'h1C, 1'b0, 1'b1, -1);
      chk("f1c_data_out", 16'(data_out), 16'(8'h1C));
      send_frame("faa", 8'hAA, 1'b1, 1'b1, -1);

      // Good then parity error then stop error.
      send_frame("g1c", 8'h1C, 1'b0, 1'b1, -1);
      send_frame("par_err", 8'h1C, 1'b1, 1'b1, -1);
      send_frame("stop_err", 8'h5A, 1'b1, 1'b0, -1);
      chk("err_data_kept", 16'(data_out), 16'(8'h1C));

      // Clock stops after 5 bits: timeout error about 200 cycles after the last fall.
      begin
         exp_t e;
         e.v = 1'b0; e.err = 1'b1; e.rr = 1'b0; e.data = last_good;
         q.push_back(e);
         err_seen = 1'b0;
         drive_bits({1'b1, 1'b0, 8'h33, 1'b0}, 5, -1);
         for (int i = 0; i < 300 && !err_seen; i++) @(negedge clk);
         total++;
         if (!err_seen || (err_cyc - fall_cyc) < 200 || (err_cyc - fall_cyc) > 215) begin
            bad++;
            $display("FAIL timeout_latency: got seen=%0b delay=%0d want 200..215",
                     err_seen, err_cyc - fall_cyc);
         end
         wait_drain("timeout");
         chk("timeout_busy", 16'(busy), 16'(0));
      end
      send_frame("f29", 8'h29, 1'b0, 1'b1, -1);

      // Short clock glitch while idle with data low must not start a frame.
      busy_seen = 1'b0;
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy) busy_seen = 1'b1;
      end
      ps2_data = 1'b1;
      chk("clk_glitch_busy", 16'(busy_seen), 16'(0));
      repeat (20) @(negedge clk);

      // Data glitch just before a data bit's fall is filtered out.
      send_frame("data_glitch", 8'h5A, 1'b1, 1'b1, 3);

      // Inhibit mid-frame: silent discard, then normal reception.
      drive_bits({1'b1, 1'b0, 8'h77, 1'b0}, 4, -1);
      inhibit = 1'b1;
      ps2_clk = 1'b0;
      repeat (30) @(negedge clk);
      chk("inhibit_busy", 16'(busy), 16'(0));
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
      inhibit = 1'b0;
      repeat (250) @(negedge clk);
      chk("inhibit_release_busy", 16'(busy), 16'(0));
      send_frame("after_inhibit", 8'h1C, 1'b0, 1'b1, -1);

      // Reset mid-frame clears everything, then a BAT frame is recognised.
      drive_bits({1'b1, 1'b1, 8'hAA, 1'b0}, 6, -1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      last_good = 8'h00;
      @(negedge clk);
      chk("midrst_data_out", 16'(data_out), 16'(0));
      chk("midrst_busy", 16'(busy), 16'(0));
      chk("midrst_strobes", 16'({data_valid, frame_error, reset_required}), 16'(0));
      repeat (250) @(negedge clk);
      chk("midrst_idle_busy", 16'(busy), 16'(0));
      send_frame("bat_after_rst", 8'hAA, 1'b1, 1'b1, -1);
      chk("bat_data_out", 16'(data_out), 16'(8'hAA));

      repeat (20) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
Upstream stage of the keyboard host path. Samples the open-collector ps2_clk/ps2_data lines and deserialises 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop). Presents each good byte with a one-cycle valid strobe. Raises reset_required when the keyboard's self-test-passed code (0xAA) arrives; that strobe triggers the downstream initial-response stage.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchroniser on each PS/2 line (minimum 2)
FILTER_LEN, 4, consecutive identical synchronised samples required before the filtered line changes
FILTER_WIDTH, 3, bits for the filter counter (must hold FILTER_LEN)
TIMEOUT_COUNT, 50000, clk cycles with no falling edge mid-frame before the frame is aborted (1 ms at 50 MHz)
TIMEOUT_WIDTH, 16, bits for the timeout counter
BAT_CODE, 8'hAA, byte value that produces reset_required

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
ps2_clk  input  1  raw PS/2 clock line (asynchronous)
ps2_data  input  1  raw PS/2 data line (asynchronous)
inhibit  input  1  high while the host drives the bus (pulldown active); receiver ignores the bus
data_out  output  8  last correctly received byte
data_valid  output  1  one-cycle strobe: data_out updated with a good byte
frame_error  output  1  one-cycle strobe: frame discarded (parity, stop or timeout)
reset_required  output  1  one-cycle strobe coincident with data_valid when byte == BAT_CODE
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: synchroniser and filter registers load 1 (idle bus), so no edge is detected on leaving reset. State goes to IDLE; bit counter, timeout counter, shift register and data_out are 0; data_valid, frame_error, reset_required and busy are 0. Reset mid-frame discards the partial frame with no strobe.
- Filter: the filtered line takes the synchronised value only after FILTER_LEN consecutive equal samples. Shorter glitches never reach the state machine.
- Edge: fall is high for one cycle when the filtered ps2_clk goes 1->0. Data is sampled from the filtered ps2_data in that same cycle.
- States:
  - IDLE: on fall with data=0, go to RECV with bit_cnt=0 and the timeout counter cleared. On fall with data=1, stay in IDLE with no strobe.
  - RECV: on each fall:
    - bit_cnt 0..7: shift data into bit[bit_cnt].
    - bit_cnt 8: capture parity.
    - bit_cnt 9: capture stop and go to CHECK.
    - bit_cnt increments on each fall.
  - RECV timeout: the timeout counter increments on every cycle without fall and clears on fall. When it reaches TIMEOUT_COUNT-1, go to IDLE and pulse frame_error.
  - CHECK (one cycle): the frame is good iff (^data ^ parity)==1 and stop==1.
    - Good: data_out <= byte; data_valid=1; reset_required=1 iff byte==BAT_CODE.
    - Bad: frame_error=1 and data_out is unchanged.
    - Always return to IDLE.
- Latency: data_valid and reset_required assert exactly 2 clk cycles after the cycle in which fall samples the stop bit. All strobes are registered.
- inhibit high: state is forced to IDLE, counters are cleared, and no strobes are produced (a partial frame is discarded silently). Filtering continues so that the filtered lines track the bus. On inhibit deassertion the receiver stays in IDLE and waits for a new start bit.
- inhibit has priority over fall in the same cycle. rst has priority over everything.
- Outputs are never X after reset. Strobes never assert in two consecutive cycles.

Test Plan:
- Frame 0x1C, parity 0, stop 1 (bench TIMEOUT_COUNT=200, PS/2 half-period 20 cycles) -> data_valid high for exactly 1 cycle, data_out=0x1C, reset_required=0, frame_error=0, busy low afterwards.
- Frame 0xAA, parity 1, stop 1 -> data_valid and reset_required both high in the same single cycle, data_out=0xAA.
- Good 0x1C, then 0x1C with parity 1 (bad), then 0x5A with stop 0 -> one frame_error strobe for each bad frame, data_out remains 0x1C, no data_valid for either bad frame.
- Clock stops after 5 bits -> frame_error pulses 200 cycles after the last fall, busy drops; the following good frame 0x29 is received correctly.
- 2-cycle low glitch on ps2_clk while IDLE with data low -> no state change and busy stays 0. A 2-cycle data glitch in mid-bit -> correct byte is still received.
- inhibit asserted after 4 bits, then released -> no strobes, busy=0. rst pulsed mid-frame on a separate run -> all outputs 0. A following good 0xAA -> reset_required strobe.
